mac_corr_bank: RTL and testbench

- Parametrised successor to the 8-bit/32-lag RAM-based MAC group. It forms a complete multi-tau correlator lag bank: acc[k] += A_now * B_(now-k) for k = 0..N-1.
- B history is held internally in a delay line, so the caller supplies one (A,B) pair per sample instead of shifting B externally.
- Adds a valid/ready sample handshake, queued clear, saturating accumulation with a sticky overflow flag, a sample counter and a read port with a valid strobe.
- Sits between the sample-time generator and the host readout logic, one instance per correlator stage.

---
 rtl/mac_corr_pkg.sv | 38 +++
 rtl/mac_corr_ram.sv | 26 ++
 rtl/mac_corr_bank.sv | 209 ++++++++++++++++++++
 tb/tb_mac_corr_bank.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_corr_pkg.sv
// Shared types, default sizes and saturating arithmetic for the correlator lag bank.
package mac_corr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_CLR  = 2'd2
   } state_t;

   localparam int unsigned DW_DEF     = 8;
   localparam int unsigned ACC_W_DEF  = 32;
   localparam int unsigned ADDR_W_DEF = 5;

   // Widest accumulator the saturating adder supports.
   localparam int unsigned SAT_W = 64;

   typedef struct packed {
      logic             ovf;
      logic [SAT_W-1:0] val;
   } sat_t;

   // Adds a product into an accumulator of width acc_w, clamping to all-ones on overflow.
   function automatic sat_t sat_add(input logic [SAT_W-1:0] acc,
                                    input logic [SAT_W-1:0] prod,
                                    input int unsigned      acc_w);
      logic [SAT_W:0] one;
      logic [SAT_W:0] sum;
      logic [SAT_W:0] lim;
      sat_t           res;
      one     = {{SAT_W{1'b0}}, 1'b1};
      sum     = {1'b0, acc} + {1'b0, prod};
      lim     = (one << acc_w) - one;
      res.ovf = (sum > lim);
      res.val = res.ovf ? lim[SAT_W-1:0] : sum[SAT_W-1:0];
      return res;
   endfunction

endpackage

// File: rtl/mac_corr_ram.sv
// Simple dual-port lag accumulator store: one synchronous read port, one write port.
module mac_corr_ram
   import mac_corr_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = ACC_W_DEF
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [1 << ADDR_W];

   // Write and registered read; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/mac_corr_bank.sv
// Multi-tau correlator lag bank: acc[k] += A_now * B_(now-k), with internal B history,
// queued clear, saturating accumulation, sample counting and a host read port.
module mac_corr_bank
   import mac_corr_pkg::*;
#(
   parameter int unsigned DW     = DW_DEF,
   parameter int unsigned ACC_W  = ACC_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DW-1:0]     a_in,
   input  logic [DW-1:0]     b_in,
   input  logic              clr,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [ACC_W-1:0]  rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              done,
   output logic              ovf,
   output logic [ACC_W-1:0]  sample_cnt
);

   localparam int unsigned     N            = 1 << ADDR_W;
   localparam logic [ADDR_W:0] MAC_LAST_CNT = (ADDR_W+1)'(N);
   localparam logic [ADDR_W:0] CLR_LAST_CNT = (ADDR_W+1)'(N - 1);

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W:0]     cnt;
   logic [DW-1:0]       a_reg;
   logic [N*DW-1:0]     hist;
   logic                clr_pend;
   logic                accept;
   logic                rd_go;
   logic                mac_last;
   logic                clr_last;

   logic [ADDR_W-1:0]   wr_k;
   logic [DW-1:0]       hist_sel;
   logic [2*DW-1:0]     prod;
   logic [SAT_W-1:0]    acc_ext;
   logic [SAT_W-1:0]    prod_ext;
   sat_t                sat_res;
   logic                unused_sat;

   logic                ram_we;
   logic [ADDR_W-1:0]   ram_waddr;
   logic [ADDR_W-1:0]   ram_raddr;
   logic [ACC_W-1:0]    ram_wdata;
   logic [ACC_W-1:0]    ram_q;
   logic [ACC_W-1:0]    rd_hold;

   assign s_ready    = rst_n && (state == ST_IDLE) && !clr_pend && !clr;
   assign busy       = (state != ST_IDLE);
   assign unused_sat = ^sat_res.val;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and per-cycle strobes; IDLE arbitrates clear > sample > read.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      rd_go     = 1'b0;
      mac_last  = 1'b0;
      clr_last  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (clr || clr_pend) begin
               state_nxt = ST_CLR;
            end else if (s_valid) begin
               accept    = 1'b1;
               state_nxt = ST_MAC;
            end else if (rd_en) begin
               rd_go = 1'b1;
            end
         end
         ST_MAC: begin
            if (cnt == MAC_LAST_CNT) begin
               mac_last  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_CLR: begin
            if (cnt == CLR_LAST_CNT) begin
               clr_last  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Pass cycle counter, restarted on every state change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (state_nxt != state) begin
         cnt <= '0;
      end else if (state != ST_IDLE) begin
         cnt <= cnt + (ADDR_W+1)'(1);
      end
   end

   // RAM port control: MAC stage 1 reads lag cnt while stage 2 writes lag cnt-1.
   always_comb begin
      wr_k                  = cnt[ADDR_W-1:0] - ADDR_W'(1);
      hist_sel              = hist[wr_k*DW +: DW];
      prod                  = {{DW{1'b0}}, a_reg} * {{DW{1'b0}}, hist_sel};
      acc_ext               = '0;
      acc_ext[ACC_W-1:0]    = ram_q;
      prod_ext              = '0;
      prod_ext[2*DW-1:0]    = prod;
      sat_res               = sat_add(acc_ext, prod_ext, ACC_W);
      ram_raddr             = rd_addr;
      ram_we                = 1'b0;
      ram_waddr             = wr_k;
      ram_wdata             = sat_res.val[ACC_W-1:0];
      case (state)
         ST_MAC: begin
            ram_raddr = cnt[ADDR_W-1:0];
            ram_we    = (cnt != '0);
         end
         ST_CLR: begin
            ram_we    = 1'b1;
            ram_waddr = cnt[ADDR_W-1:0];
            ram_wdata = '0;
         end
         default: ;
      endcase
   end

   // B history delay line and latched A, both updated on sample accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist  <= '0;
         a_reg <= '0;
      end else if (accept) begin
         hist  <= {hist[(N-1)*DW-1:0], b_in};
         a_reg <= a_in;
      end
   end

   // Status: queued clear, sticky overflow, saturating sample count, end-of-pass pulse.
   // A clr seen during a CLR pass is absorbed into that pass.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_pend   <= 1'b0;
         ovf        <= 1'b0;
         sample_cnt <= '0;
         done       <= 1'b0;
      end else begin
         done <= mac_last || clr_last;
         if (clr_last) begin
            clr_pend   <= 1'b0;
            ovf        <= 1'b0;
            sample_cnt <= '0;
         end else begin
            if (clr && (state == ST_MAC)) begin
               clr_pend <= 1'b1;
            end
            if ((state == ST_MAC) && ram_we && sat_res.ovf) begin
               ovf <= 1'b1;
            end
            if (accept && (sample_cnt != '1)) begin
               sample_cnt <= sample_cnt + ACC_W'(1);
            end
         end
      end
   end

   // Host read result: RAM output is presented directly in the valid cycle and held after.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
         rd_hold  <= '0;
      end else begin
         rd_valid <= rd_go;
         if (rd_valid) begin
            rd_hold <= ram_q;
         end
      end
   end

   assign rd_data = rd_valid ? ram_q : rd_hold;

   mac_corr_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (ACC_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (ram_raddr),
      .rdata (ram_q)
   );

endmodule

// File: tb/tb_mac_corr_bank.sv
// Directed bench for mac_corr_bank: a 32-bit and a 16-bit instance driven in lockstep.
module tb_mac_corr_bank;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_valid = 1'b0;
   logic        clr = 1'b0;
   logic        rd_en = 1'b0;
   logic [7:0]  a_in = '0;
   logic [7:0]  b_in = '0;
   logic [4:0]  rd_addr = '0;

   logic        s_ready, rd_valid, busy, done, ovf;
   logic [31:0] rd_data, sample_cnt;
   logic        s_ready16, rd_valid16, busy16, done16, ovf16;
   logic [15:0] rd_data16, sample_cnt16;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mac_corr_bank #(.DW(8), .ACC_W(32), .ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
      .a_in(a_in), .b_in(b_in), .clr(clr), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
      .ovf(ovf), .sample_cnt(sample_cnt)
   );

   mac_corr_bank #(.DW(8), .ACC_W(16), .ADDR_W(5)) dut16 (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready16),
      .a_in(a_in), .b_in(b_in), .clr(clr), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data16), .rd_valid(rd_valid16), .busy(busy16), .done(done16),
      .ovf(ovf16), .sample_cnt(sample_cnt16)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic send_sample(input logic [7:0] a, input logic [7:0] b, output bit ok);
      ok = 1'b0;
      a_in = a;
      b_in = b;
      s_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (s_ready) begin
            ok = 1'b1;
            tick();
            break;
         end
         tick();
      end
      s_valid = 1'b0;
   endtask

   task automatic run_sample(input logic [7:0] a, input logic [7:0] b, output bit ok);
      bit ok2;
      send_sample(a, b, ok);
      wait_done(ok2);
      ok = ok && ok2;
   endtask

   task automatic do_clr(output bit ok);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      wait_done(ok);
   endtask

   task automatic read_lag(input logic [4:0] addr, output logic [31:0] d,
                           output logic [15:0] d16, output logic v);
      rd_en = 1'b1;
      rd_addr = addr;
      tick();
      rd_en = 1'b0;
      d = rd_data;
      d16 = rd_data16;
      v = rd_valid;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
      checks++; if (s_ready16 !== 1'b0) begin errors++; $display("FAIL reset_s_ready16: got %b expected 0", s_ready16); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
      checks++; if (sample_cnt !== 32'd0) begin errors++; $display("FAIL reset_sample_cnt: got %0d expected 0", sample_cnt); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
      checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd_data: got %0d expected 0", rd_data); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL post_reset_s_ready: got %b expected 1", s_ready); end
      checks++; if (rd_valid16 !== 1'b0) begin errors++; $display("FAIL post_reset_rd_valid16: got %b expected 0", rd_valid16); end
   endtask

   task automatic test_clear();
      int n;
      logic [31:0] d;
      logic [15:0] d16;
      logic v;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      n = 0;
      while (busy && n < 200) begin
         n++;
         tick();
      end
      checks++; if (n != 32) begin errors++; $display("FAIL clr_busy_cycles: got %0d expected 32", n); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL clr_done: got %b expected 1", done); end
      checks++; if (done16 !== 1'b1 || busy16 !== 1'b0) begin errors++; $display("FAIL clr_done16: got done=%b busy=%b expected 1/0", done16, busy16); end
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL clr_done_pulse: got %b expected 0", done); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %b expected 0", ovf); end
      checks++; if (sample_cnt !== 32'd0) begin errors++; $display("FAIL clr_sample_cnt: got %0d expected 0", sample_cnt); end
      for (int k = 0; k < 32; k++) begin
         read_lag(5'(k), d, d16, v);
         checks++; if (v !== 1'b1 || d !== 32'd0) begin errors++; $display("FAIL clr_lag%0d: got valid=%b data=%0d expected 1/0", k, v, d); end
      end
      read_lag(5'd0, d, d16, v);
      checks++; if (d16 !== 16'd0) begin errors++; $display("FAIL clr_lag0_16: got %0d expected 0", d16); end
   endtask

   task automatic test_mac_basic();
      bit ok;
      int n;
      logic [31:0] d, exp;
      logic [15:0] d16;
      logic v;
      for (int i = 0; i < 5; i++) begin
         send_sample(8'd3, 8'd3, ok);
         checks++; if (!ok) begin errors++; $display("FAIL mac_accept%0d: got timeout expected accept", i); end
         n = 0;
         while (busy && n < 200) begin
            n++;
            tick();
         end
         checks++; if (n != 33) begin errors++; $display("FAIL mac_busy_cycles%0d: got %0d expected 33", i, n); end
         checks++; if (done !== 1'b1) begin errors++; $display("FAIL mac_done%0d: got %b expected 1", i, done); end
      end
      checks++; if (sample_cnt !== 32'd5) begin errors++; $display("FAIL mac_sample_cnt: got %0d expected 5", sample_cnt); end
      checks++; if (sample_cnt16 !== 16'd5) begin errors++; $display("FAIL mac_sample_cnt16: got %0d expected 5", sample_cnt16); end
      for (int k = 0; k < 32; k++) begin
         exp = (k < 5) ? 32'(9 * (5 - k)) : 32'd0;
         read_lag(5'(k), d, d16, v);
         checks++; if (v !== 1'b1 || d !== exp) begin errors++; $display("FAIL mac_lag%0d: got valid=%b data=%0d expected 1/%0d", k, v, d, exp); end
      end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL mac_ovf: got %b expected 0", ovf); end
   endtask

   task automatic test_saturation();
      bit ok;
      logic [31:0] d;
      logic [15:0] d16;
      logic v;
      do_clr(ok);
      checks++; if (!ok) begin errors++; $display("FAIL sat_clr1: got timeout expected done"); end
      run_sample(8'd255, 8'd255, ok);
      run_sample(8'd255, 8'd255, ok);
      checks++; if (!ok) begin errors++; $display("FAIL sat_samples: got timeout expected done"); end
      read_lag(5'd0, d, d16, v);
      checks++; if (d16 !== 16'hFFFF) begin errors++; $display("FAIL sat_lag0_16: got %h expected ffff", d16); end
      checks++; if (d !== 32'd130050) begin errors++; $display("FAIL sat_lag0_32: got %0d expected 130050", d); end
      read_lag(5'd1, d, d16, v);
      checks++; if (d16 !== 16'hFFFF) begin errors++; $display("FAIL sat_lag1_16: got %h expected ffff", d16); end
      checks++; if (d !== 32'd65790) begin errors++; $display("FAIL sat_lag1_32: got %0d expected 65790", d); end
      read_lag(5'd2, d, d16, v);
      checks++; if (d16 !== 16'd1530) begin errors++; $display("FAIL sat_lag2_16: got %0d expected 1530", d16); end
      checks++; if (ovf16 !== 1'b1) begin errors++; $display("FAIL sat_ovf16: got %b expected 1", ovf16); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sat_ovf32: got %b expected 0", ovf); end
      do_clr(ok);
      checks++; if (!ok) begin errors++; $display("FAIL sat_clr2: got timeout expected done"); end
      tick();
      read_lag(5'd0, d, d16, v);
      checks++; if (d16 !== 16'd0) begin errors++; $display("FAIL sat_after_clr_lag0: got %0d expected 0", d16); end
      checks++; if (ovf16 !== 1'b0) begin errors++; $display("FAIL sat_after_clr_ovf16: got %b expected 0", ovf16); end
      checks++; if (sample_cnt !== 32'd0) begin errors++; $display("FAIL sat_after_clr_cnt: got %0d expected 0", sample_cnt); end
   endtask

   task automatic test_clr_mid_mac();
      bit ok;
      int busy_cnt, done_cnt, first_done_c, clr_start_c, ready_bad;
      logic [31:0] d;
      logic [15:0] d16;
      logic v;
      busy_cnt = 0; done_cnt = 0; first_done_c = -1; clr_start_c = -1; ready_bad = 0;
      send_sample(8'd1, 8'd1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL midclr_accept: got timeout expected accept"); end
      for (int c = 1; c <= 80; c++) begin
         if (c == 6) clr = 1'b1;
         if (c == 7) clr = 1'b0;
         #1;
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (first_done_c < 0) first_done_c = c;
         end
         if (first_done_c >= 0 && c > first_done_c && busy && clr_start_c < 0) clr_start_c = c;
         if (done_cnt < 2 && s_ready !== 1'b0) ready_bad++;
         tick();
      end
      checks++; if (done_cnt != 2) begin errors++; $display("FAIL midclr_done_pulses: got %0d expected 2", done_cnt); end
      checks++; if (first_done_c != 34) begin errors++; $display("FAIL midclr_mac_end: got cycle %0d expected 34", first_done_c); end
      checks++; if (clr_start_c != 35) begin errors++; $display("FAIL midclr_clr_start: got cycle %0d expected 35", clr_start_c); end
      checks++; if (busy_cnt != 65) begin errors++; $display("FAIL midclr_busy_cycles: got %0d expected 65", busy_cnt); end
      checks++; if (ready_bad != 0) begin errors++; $display("FAIL midclr_s_ready: got %0d ready cycles expected 0", ready_bad); end
      checks++; if (sample_cnt !== 32'd0) begin errors++; $display("FAIL midclr_sample_cnt: got %0d expected 0", sample_cnt); end
      for (int k = 0; k < 32; k++) begin
         read_lag(5'(k), d, d16, v);
         checks++; if (v !== 1'b1 || d !== 32'd0) begin errors++; $display("FAIL midclr_lag%0d: got valid=%b data=%0d expected 1/0", k, v, d); end
      end
   endtask

   task automatic test_read_arb();
      bit ok;
      int n, bad;
      logic [31:0] d;
      logic [15:0] d16;
      logic v;
      run_sample(8'd2, 8'd5, ok);
      checks++; if (!ok) begin errors++; $display("FAIL arb_sample1: got timeout expected done"); end
      read_lag(5'd2, d, d16, v);
      checks++; if (d !== 32'd510) begin errors++; $display("FAIL arb_lag2: got %0d expected 510", d); end
      send_sample(8'd1, 8'd0, ok);
      rd_en = 1'b1;
      rd_addr = 5'd0;
      n = 0; bad = 0;
      while (busy && n < 200) begin
         if (rd_valid !== 1'b0 || rd_data !== 32'd510) bad++;
         n++;
         tick();
      end
      rd_en = 1'b0;
      checks++; if (bad != 0 || n != 33) begin errors++; $display("FAIL arb_rd_during_busy: got %0d bad of %0d cycles expected 0 of 33", bad, n); end
      s_valid = 1'b1; a_in = 8'd0; b_in = 8'd0;
      rd_en = 1'b1; rd_addr = 5'd3;
      tick();
      s_valid = 1'b0; rd_en = 1'b0;
      checks++; if (rd_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL arb_sample_wins: got rd_valid=%b busy=%b expected 0/1", rd_valid, busy); end
      checks++; if (rd_data !== 32'd510) begin errors++; $display("FAIL arb_rd_hold: got %0d expected 510", rd_data); end
      wait_done(ok);
      rd_en = 1'b1; rd_addr = 5'd0;
      tick();
      checks++; if (rd_valid !== 1'b1 || rd_data !== 32'd10) begin errors++; $display("FAIL b2b_lag0: got valid=%b data=%0d expected 1/10", rd_valid, rd_data); end
      rd_addr = 5'd1;
      tick();
      checks++; if (rd_valid !== 1'b1 || rd_data !== 32'd7) begin errors++; $display("FAIL b2b_lag1: got valid=%b data=%0d expected 1/7", rd_valid, rd_data); end
      rd_addr = 5'd3;
      tick();
      checks++; if (rd_valid !== 1'b1 || rd_data !== 32'd765) begin errors++; $display("FAIL b2b_lag3: got valid=%b data=%0d expected 1/765", rd_valid, rd_data); end
      rd_en = 1'b0;
      tick();
      checks++; if (rd_valid !== 1'b0 || rd_data !== 32'd765) begin errors++; $display("FAIL b2b_hold: got valid=%b data=%0d expected 0/765", rd_valid, rd_data); end
      read_lag(5'd4, d, d16, v);
      checks++; if (d !== 32'd261) begin errors++; $display("FAIL arb_lag4: got %0d expected 261", d); end
      checks++; if (sample_cnt !== 32'd3) begin errors++; $display("FAIL arb_sample_cnt: got %0d expected 3", sample_cnt); end
   endtask

   task automatic test_reset_mid_pass();
      bit ok;
      logic [31:0] d;
      logic [15:0] d16;
      logic v;
      send_sample(8'd1, 8'd1, ok);
      repeat (9) tick();
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rstmid_s_ready: got %b expected 0", s_ready); end
      tick();
      tick();
      checks++; if (s_ready !== 1'b0 || sample_cnt !== 32'd0) begin errors++; $display("FAIL rstmid_hold: got s_ready=%b cnt=%0d expected 0/0", s_ready, sample_cnt); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      checks++; if (s_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_release: got s_ready=%b busy=%b expected 1/0", s_ready, busy); end
      do_clr(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rstmid_clr: got timeout expected done"); end
      tick();
      for (int k = 0; k < 32; k++) begin
         read_lag(5'(k), d, d16, v);
         checks++; if (v !== 1'b1 || d !== 32'd0) begin errors++; $display("FAIL rstmid_lag%0d: got valid=%b data=%0d expected 1/0", k, v, d); end
      end
      run_sample(8'd2, 8'd2, ok);
      read_lag(5'd0, d, d16, v);
      checks++; if (d !== 32'd4) begin errors++; $display("FAIL rstmid_new_lag0: got %0d expected 4", d); end
      read_lag(5'd1, d, d16, v);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL rstmid_new_lag1: got %0d expected 0", d); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_clear();
      test_mac_basic();
      test_saturation();
      test_clr_mid_mac();
      test_read_arb();
      test_reset_mid_pass();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
